fma16_qcalc: RTL and testbench

//  Iterative FP16 significand divider: the inverse of the FMA16 product calculator. From unpacked x/y

---
 rtl/fma16_qcalc.sv | 154 +++++++++++++++
 tb/tb_fma16_qcalc.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fma16_qcalc.sv
// Iterative FP16 significand divider: restoring radix-2, one quotient bit per clock.
// Produces quotient sign, rebiased exponent, raw QBITS-bit significand and sticky for the shared rounder.
module fma16_qcalc #(
    parameter int QBITS = 21,
    parameter int BIAS  = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             xs,
    input  logic             ys,
    input  logic [4:0]       xe,
    input  logic [4:0]       ye,
    input  logic [9:0]       xm,
    input  logic [9:0]       ym,
    input  logic             x_zero,
    input  logic             y_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             qs,
    output logic [6:0]       qe,
    output logic [QBITS:0]   mid_qm,
    output logic             sticky,
    output logic             div_by_zero,
    output logic             invalid
);

    localparam int CW = $clog2(QBITS);
    localparam logic signed [7:0] BIAS8 = 8'(BIAS);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DIV,
        DONE
    } state_t;

    state_t            state_q;
    logic [4:0]        xe_q, ye_q;
    logic [9:0]        xm_q, ym_q;
    logic              qs_q;
    logic [6:0]        qe_q;
    logic [QBITS-1:0]  quot_q;
    logic              sticky_q;
    logic              divZero_q;
    logic              invalid_q;
    logic [11:0]       rem_q;
    logic [10:0]       bNorm_q;
    logic [CW-1:0]     iter_q;

    logic [10:0]       aRaw, bRaw, aNorm_d, bNorm_d;
    logic [3:0]        lzA, lzB;
    logic signed [7:0] effA, effB, qeFull_d;
    logic              qBit_d;
    logic [11:0]       remNext_d;

    // Normalization of the latched operands and one restoring-division step.
    always_comb begin
        aRaw = {xe_q != 5'd0, xm_q};
        bRaw = {ye_q != 5'd0, ym_q};
        lzA  = 4'd0;
        lzB  = 4'd0;
        for (int i = 0; i < 11; i++) begin
            if (aRaw[i]) lzA = 4'(10 - i);
            if (bRaw[i]) lzB = 4'(10 - i);
        end
        aNorm_d  = aRaw << lzA;
        bNorm_d  = bRaw << lzB;
        effA     = (xe_q != 5'd0) ? $signed({3'b000, xe_q}) : 8'sd1 - $signed({4'b0000, lzA});
        effB     = (ye_q != 5'd0) ? $signed({3'b000, ye_q}) : 8'sd1 - $signed({4'b0000, lzB});
        qeFull_d = effA - effB + BIAS8;

        qBit_d    = rem_q >= {1'b0, bNorm_q};
        remNext_d = qBit_d ? (rem_q - {1'b0, bNorm_q}) << 1 : rem_q << 1;
    end

    // Control FSM and datapath registers; zero operands bypass straight to DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            xe_q      <= '0;
            ye_q      <= '0;
            xm_q      <= '0;
            ym_q      <= '0;
            qs_q      <= 1'b0;
            qe_q      <= '0;
            quot_q    <= '0;
            sticky_q  <= 1'b0;
            divZero_q <= 1'b0;
            invalid_q <= 1'b0;
            rem_q     <= '0;
            bNorm_q   <= '0;
            iter_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        xe_q <= xe;
                        ye_q <= ye;
                        xm_q <= xm;
                        ym_q <= ym;
                        qs_q <= xs ^ ys;
                        if (x_zero || y_zero) begin
                            qe_q      <= '0;
                            quot_q    <= '0;
                            sticky_q  <= 1'b0;
                            divZero_q <= y_zero & ~x_zero;
                            invalid_q <= x_zero & y_zero;
                            state_q   <= DONE;
                        end else begin
                            state_q <= NORM;
                        end
                    end
                end
                NORM: begin
                    rem_q   <= {1'b0, aNorm_d};
                    bNorm_q <= bNorm_d;
                    qe_q    <= qeFull_d[6:0];
                    quot_q  <= '0;
                    iter_q  <= '0;
                    state_q <= DIV;
                end
                DIV: begin
                    rem_q  <= remNext_d;
                    quot_q <= {quot_q[QBITS-2:0], qBit_d};
                    iter_q <= iter_q + 1'b1;
                    if (iter_q == CW'(QBITS - 1)) begin
                        sticky_q <= remNext_d != 12'd0;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        divZero_q <= 1'b0;
                        invalid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign qs          = qs_q;
    assign qe          = qe_q;
    assign mid_qm      = {1'b0, quot_q};
    assign sticky      = sticky_q;
    assign div_by_zero = divZero_q;
    assign invalid     = invalid_q;

endmodule

// File: tb/tb_fma16_qcalc.sv
// Bench for fma16_qcalc: directed literal cases, then randomized traffic checked every cycle
// against an arithmetic quotient model.
module tb_fma16_qcalc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        xs = 1'b0, ys = 1'b0;
    logic [4:0]  xe = '0, ye = '0;
    logic [9:0]  xm = '0, ym = '0;
    logic        x_zero = 1'b0, y_zero = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        qs;
    logic [6:0]  qe;
    logic [21:0] mid_qm;
    logic        sticky;
    logic        div_by_zero;
    logic        invalid;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit checkOn = 1'b0;

    typedef struct {
        logic        qs;
        logic [6:0]  qe;
        logic [21:0] mqm;
        logic        st;
        logic        dz;
        logic        inv;
    } res_t;

    bit   mBusy = 1'b0;
    bit   expValid;
    int   mDoneCyc = 0;
    res_t mExp;

    fma16_qcalc #(.QBITS(21), .BIAS(15)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .xs(xs), .ys(ys), .xe(xe), .ye(ye), .xm(xm), .ym(ym),
        .x_zero(x_zero), .y_zero(y_zero), .out_valid(out_valid), .out_ready(out_ready),
        .qs(qs), .qe(qe), .mid_qm(mid_qm), .sticky(sticky),
        .div_by_zero(div_by_zero), .invalid(invalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Quotient of the two values: normalize each significand to [1024,2048) and divide exactly.
    function automatic res_t refDivide(input logic sx, input logic [4:0] ex, input logic [9:0] mx,
                                       input logic sy, input logic [4:0] ey, input logic [9:0] my,
                                       input logic zx, input logic zy);
        res_t   r;
        longint a, b, num;
        int     expX, expY;
        r.qs  = sx ^ sy;
        r.qe  = '0;
        r.mqm = '0;
        r.st  = 1'b0;
        r.dz  = zy && !zx;
        r.inv = zx && zy;
        if (zx || zy) return r;
        a    = (ex != 0) ? 1024 + longint'(mx) : longint'(mx);
        b    = (ey != 0) ? 1024 + longint'(my) : longint'(my);
        expX = (ex != 0) ? int'(ex) : 1;
        expY = (ey != 0) ? int'(ey) : 1;
        while (a < 1024) begin a = a * 2; expX--; end
        while (b < 1024) begin b = b * 2; expY--; end
        num   = a << 20;
        r.mqm = 22'(num / b);
        r.st  = (num % b) != 0;
        r.qe  = 7'(expX - expY + 15);
        return r;
    endfunction

    // Reference comparison every cycle; the model then advances for the coming edge.
    always @(negedge clk) begin
        if (checkOn) begin
            expValid = mBusy && (cyc >= mDoneCyc);
            checkOutput("in_ready", 32'(in_ready), 32'(!mBusy));
            checkOutput("out_valid", 32'(out_valid), 32'(expValid));
            if (expValid) begin
                checkOutput("qs", 32'(qs), 32'(mExp.qs));
                checkOutput("qe", 32'(qe), 32'(mExp.qe));
                checkOutput("mid_qm", 32'(mid_qm), 32'(mExp.mqm));
                checkOutput("sticky", 32'(sticky), 32'(mExp.st));
                checkOutput("div_by_zero", 32'(div_by_zero), 32'(mExp.dz));
                checkOutput("invalid", 32'(invalid), 32'(mExp.inv));
            end
            if (reset) begin
                mBusy = 1'b0;
            end else if (expValid && out_ready) begin
                mBusy = 1'b0;
            end else if (!mBusy && in_valid) begin
                mExp     = refDivide(xs, xe, xm, ys, ye, ym, x_zero, y_zero);
                mBusy    = 1'b1;
                mDoneCyc = cyc + 1 + ((x_zero || y_zero) ? 0 : 22);
            end
        end
    end

    // Drives one operation from an idle DUT; returns edges from accept until out_valid.
    task automatic applyStimulus(input logic sx, input logic [4:0] ex, input logic [9:0] mx,
                                 input logic sy, input logic [4:0] ey, input logic [9:0] my,
                                 input logic zx, input logic zy, output int lat);
        xs = sx; xe = ex; xm = mx; ys = sy; ye = ey; ym = my;
        x_zero = zx; y_zero = zy;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) checkOutput("result_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic checkResult(input string tag, input logic eqs, input logic [6:0] eqe,
                               input logic [21:0] emqm, input logic est, input logic edz,
                               input logic einv);
        checkOutput({tag, "_qs"}, 32'(qs), 32'(eqs));
        checkOutput({tag, "_qe"}, 32'(qe), 32'(eqe));
        checkOutput({tag, "_mid_qm"}, 32'(mid_qm), 32'(emqm));
        checkOutput({tag, "_sticky"}, 32'(sticky), 32'(est));
        checkOutput({tag, "_dbz"}, 32'(div_by_zero), 32'(edz));
        checkOutput({tag, "_invalid"}, 32'(invalid), 32'(einv));
    endtask

    task automatic randomOperands();
        xs = 1'($urandom);
        ys = 1'($urandom);
        xe = 5'($urandom_range(0, 30));
        ye = 5'($urandom_range(0, 30));
        xm = 10'($urandom);
        ym = 10'($urandom);
        x_zero = ($urandom_range(0, 15) == 0);
        y_zero = ($urandom_range(0, 15) == 0);
        if (x_zero) begin xe = '0; xm = '0; end
        else if (xe == 0 && xm == 0) xm = 10'd1;
        if (y_zero) begin ye = '0; ym = '0; end
        else if (ye == 0 && ym == 0) ym = 10'd1;
    endtask

    initial begin
        int lat;
        int waitCnt;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkResult("reset", 1'b0, 7'h00, 22'h0, 1'b0, 1'b0, 1'b0);
        checkOn = 1'b1;
        @(posedge clk); #2;

        applyStimulus(1'b0, 5'd15, 10'h000, 1'b0, 5'd15, 10'h000, 1'b0, 1'b0, lat);
        checkOutput("one_by_one_latency", 32'(lat), 32'd23);
        checkResult("one_by_one", 1'b0, 7'd15, 22'h100000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;

        applyStimulus(1'b0, 5'd16, 10'h200, 1'b0, 5'd16, 10'h000, 1'b0, 1'b0, lat);
        checkResult("three_by_two", 1'b0, 7'd15, 22'h180000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;

        applyStimulus(1'b1, 5'd15, 10'h000, 1'b0, 5'd16, 10'h200, 1'b0, 1'b0, lat);
        checkResult("neg_one_by_three", 1'b1, 7'd14, 22'h0AAAAA, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #2;

        applyStimulus(1'b0, 5'd0, 10'h001, 1'b0, 5'd15, 10'h000, 1'b0, 1'b0, lat);
        checkResult("subnormal", 1'b0, 7'h77, 22'h100000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;

        applyStimulus(1'b1, 5'd20, 10'h155, 1'b1, 5'd0, 10'h000, 1'b0, 1'b1, lat);
        checkOutput("div_zero_latency", 32'(lat), 32'd1);
        checkResult("div_zero", 1'b0, 7'h00, 22'h0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #2;

        applyStimulus(1'b0, 5'd0, 10'h000, 1'b1, 5'd0, 10'h000, 1'b1, 1'b1, lat);
        checkResult("zero_by_zero", 1'b1, 7'h00, 22'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #2;

        // Consumer stalls while new operands are offered.
        out_ready = 1'b0;
        applyStimulus(1'b0, 5'd16, 10'h200, 1'b0, 5'd16, 10'h000, 1'b0, 1'b0, lat);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            randomOperands();
            in_valid = 1'b1;
            @(negedge clk);
            checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("stall_mid_qm", 32'(mid_qm), 32'h180000);
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #2;

        // Reset while the division is in progress.
        applyStimulus(1'b1, 5'd15, 10'h000, 1'b0, 5'd16, 10'h200, 1'b0, 1'b0, lat);
        @(posedge clk); #2;
        xs = 1'b1; xe = 5'd15; xm = '0; ys = 1'b0; ye = 5'd16; ym = 10'h200;
        x_zero = 1'b0; y_zero = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        checkResult("midreset", 1'b0, 7'h00, 22'h0, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            randomOperands();
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
        out_ready = 1'b1;
        waitCnt = 0;
        while (mBusy && waitCnt < 60) begin
            @(posedge clk); #2;
            waitCnt++;
        end
        checkOutput("drain_idle", 32'(mBusy), 32'd0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
